// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, framebuffer geometry and colour encoding
// for the plot-to-VGA scanout slice.
package vga_timing_pkg;

   localparam int unsigned H_VIS   = 640;
   localparam int unsigned H_FP    = 16;
   localparam int unsigned H_SYNC  = 96;
   localparam int unsigned H_BP    = 48;
   localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_VIS   = 480;
   localparam int unsigned V_FP    = 10;
   localparam int unsigned V_SYNC  = 2;
   localparam int unsigned V_BP    = 33;
   localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam int unsigned H_SYNC_START = H_VIS + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int unsigned V_SYNC_START = V_VIS + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   localparam int unsigned FB_W     = 160;
   localparam int unsigned FB_H     = 120;
   localparam int unsigned FB_DEPTH = FB_W * FB_H;
   localparam int unsigned FB_AW    = 15;

   localparam int unsigned COL_R = 2;
   localparam int unsigned COL_G = 1;
   localparam int unsigned COL_B = 0;

   typedef logic [2:0] colour_t;

   typedef struct packed {
      logic vis;
      logic hs_n;
      logic vs_n;
   } scan_flags_t;

   // row*160 + col without a multiplier: row*128 + row*32 + col
   function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] col, input logic [7:0] row);
      logic [FB_AW-1:0] r;
      r = FB_AW'(row);
      return (r << 7) + (r << 5) + FB_AW'(col);
   endfunction

   function automatic logic [9:0] expand(input colour_t c, input int unsigned bit_pos);
      return c[bit_pos] ? '1 : '0;
   endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Single-pixel plot bus between drawing FSMs (master) and the scanout (slave).
interface vga_scanout_if;
   logic       plot;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;

   modport master (output plot, x, y, colour);
   modport slave  (input  plot, x, y, colour);
endinterface

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port,
// no reset so it maps onto block RAM.
module fb_ram #(
   parameter int unsigned DEPTH = vga_timing_pkg::FB_DEPTH,
   parameter int unsigned AW    = vga_timing_pkg::FB_AW,
   parameter int unsigned DW    = 3
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Same-address read and write in one clock returns the old word.
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_scanout.sv
// Plot-bus pixel sink: 160x120x3 framebuffer scanned out as 640x480@60 VGA
// with 4x4 pixel replication and a 2-tick address/read/output pipeline.
module vga_scanout #(
   parameter int unsigned H_VIS  = vga_timing_pkg::H_VIS,
   parameter int unsigned H_FP   = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP   = vga_timing_pkg::H_BP,
   parameter int unsigned V_VIS  = vga_timing_pkg::V_VIS,
   parameter int unsigned V_FP   = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP   = vga_timing_pkg::V_BP
) (
   input  logic          clock,
   input  logic          reset,
   vga_scanout_if.slave  plot_bus,
   output logic          VGA_CLK,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          VGA_BLANK_N,
   output logic          VGA_SYNC_N,
   output logic [9:0]    VGA_R,
   output logic [9:0]    VGA_G,
   output logic [9:0]    VGA_B
);

   import vga_timing_pkg::FB_W;
   import vga_timing_pkg::FB_H;
   import vga_timing_pkg::FB_AW;
   import vga_timing_pkg::COL_R;
   import vga_timing_pkg::COL_G;
   import vga_timing_pkg::COL_B;
   import vga_timing_pkg::colour_t;
   import vga_timing_pkg::scan_flags_t;
   import vga_timing_pkg::fb_addr;
   import vga_timing_pkg::expand;

   localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
   localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
   localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

   logic             pix_en;
   logic [9:0]       h, v;
   scan_flags_t      flags_c, flags1, flags2;
   logic [FB_AW-1:0] addr_c, addr1;
   colour_t          rd_data;
   logic             we;
   logic [FB_AW-1:0] waddr;

   assign VGA_SYNC_N = 1'b0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_en  <= 1'b0;
         VGA_CLK <= 1'b0;
      end else begin
         pix_en  <= ~pix_en;
         VGA_CLK <= ~pix_en;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (pix_en) begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
         end else begin
            h <= h + 10'd1;
         end
      end
   end

   always_comb begin
      flags_c      = '0;
      flags_c.vis  = (h < H_VIS_L) && (v < V_VIS_L);
      flags_c.hs_n = !((h >= HS_START) && (h <= HS_END));
      flags_c.vs_n = !((v >= VS_START) && (v <= VS_END));
      // Off-screen positions read address 0 so the RAM index stays in range.
      addr_c       = flags_c.vis ? fb_addr(h[9:2], v[9:2]) : '0;
   end

   always_comb begin
      we    = plot_bus.plot && (plot_bus.x < 8'(FB_W)) && (plot_bus.y < 7'(FB_H));
      waddr = fb_addr(plot_bus.x, {1'b0, plot_bus.y});
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         flags1 <= '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
         flags2 <= '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};
         addr1  <= '0;
      end else if (pix_en) begin
         flags1 <= flags_c;
         flags2 <= flags1;
         addr1  <= addr_c;
      end
   end

   fb_ram #(
      .DEPTH (vga_timing_pkg::FB_DEPTH),
      .AW    (FB_AW),
      .DW    (3)
   ) u_fb_ram (
      .clock (clock),
      .we    (we),
      .waddr (waddr),
      .wdata (plot_bus.colour),
      .re    (pix_en),
      .raddr (addr1),
      .rdata (rd_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else if (pix_en) begin
         VGA_HS      <= flags2.hs_n;
         VGA_VS      <= flags2.vs_n;
         VGA_BLANK_N <= flags2.vis;
         VGA_R       <= flags2.vis ? expand(rd_data, COL_R) : '0;
         VGA_G       <= flags2.vis ? expand(rd_data, COL_G) : '0;
         VGA_B       <= flags2.vis ? expand(rd_data, COL_B) : '0;
      end
   end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Pixel-sink and display end of the plot interface. Accepts single-pixel writes as `plot`/`x`/`y`/`colour` from drawing FSMs such as the keyboard GUI controller/datapath. Stores them in a 160x120x3-bit framebuffer. Continuously scans the framebuffer out as 640x480@60 Hz VGA, replicating each pixel 4x4, to drive the board DAC pins directly.

## Interface
- `H_VIS` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixel ticks.
- `V_VIS` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.
- `FB_W` 160, `FB_H` 120: framebuffer dimensions.
- `clock` in 1: 50 MHz system clock.
- `reset` in 1: asynchronous, active-high.
- `plot` in 1: write strobe, one pixel per clock when high.
- `x` in 8: write column, 0..159.
- `y` in 7: write row, 0..119.
- `colour` in 3: {R,G,B}, bit 2 = R.
- `VGA_CLK` out 1: 25 MHz pixel clock.
- `VGA_HS` out 1: horizontal sync, active low.
- `VGA_VS` out 1: vertical sync, active low.
- `VGA_BLANK_N` out 1: high in the visible area.
- `VGA_SYNC_N` out 1: tied 0, no sync-on-green.
- `VGA_R`, `VGA_G`, `VGA_B` out 10 each: channel intensity.

## Operation
- **Pixel enable.** `pix_en` toggles every clock and is 1 on the first clock after reset release. All scan logic advances only when `pix_en`=1. `VGA_CLK` is registered `~pix_en`.
- **Counters.**
  - `h` counts 0..799 and wraps to 0.
  - `v` increments when `h` wraps, counts 0..524, and wraps to 0.
- **Visible area.** `h`<640 and `v`<480.
- **Sync windows.**
  - HS low for `h` in 656..751.
  - VS low for `v` in 490..491.
- **Read address.** `(v>>2)*160 + (h>>2)`, built as `(v>>2)<<7 + (v>>2)<<5 + (h>>2)`, 15 bits. Used only when visible; otherwise don't-care.
- **Write path.**
  - On any clock with `plot`=1, `x`<160 and `y`<120: `mem[y*160+x] <= colour`.
  - Writes with `x`>=160 or `y`>=120 are dropped, with no wrap into other rows.
  - No backpressure; writes are accepted on every clock regardless of `pix_en`.
- **Read/write collision.** Same address in the same clock: the read returns the old data and the new value is visible from the next read.
- **Colour expansion.** Each channel is 10'h3FF if its bit is 1, else 10'h000. RGB is forced to 0 while not visible.
- **Reset values.**
  - `h`=0, `v`=0, `pix_en`=0.
  - `VGA_CLK`=0, `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0, `VGA_SYNC_N`=0, RGB=0.
- **Memory contents.** Not cleared by reset, and retained across a mid-frame reset. Simulation initialises the memory to 0.
- **Reset mid-operation.** Counters restart at (0,0) and the pipeline is flushed to reset values. A write in the same clock as reset assertion may be lost.

## Timing
- **Scan pipeline, 2 pixel ticks.**
  - Tick n: counters hold (h,v); address and visible/sync flags are registered.
  - Tick n+1: memory read is registered; flags are delayed one stage.
  - Tick n+2: outputs are registered.
- **Alignment.** HS, VS, BLANK_N and RGB at tick n+2 all correspond to (h,v) of tick n, so sync and pixel data stay aligned.
- **Line period.** 800 ticks = 1600 clocks; HS low for 96 ticks = 192 clocks.
- **Frame period.** 525 lines = 840 000 clocks.
- **Output updates.** Outputs change only on clocks with `pix_en`=1, where `VGA_CLK` falls. `VGA_CLK` rises mid-pixel.
- **Write-to-display latency.** A pixel is displayed from the next scan pass of its block. There is no frame buffering or tearing protection.

## Structure
- **`vga_timing_pkg`** holds:
  - H/V timing constants and derived totals (800, 525);
  - sync start/end values;
  - `FB_W`, `FB_H`, `FB_DEPTH`=19200;
  - the colour encoding ({R,G,B} bit positions).
- **`fb_ram`**: simple dual-port RAM, 19200x3, with one write port and one registered read port. It must infer block RAM and has no reset.
- **`vga_scanout`**: counters, address generation, pipeline and output registers.

## Test plan
- **Reset values.** Assert `reset` mid-simulation -> every output equals its reset value within the same clock (asynchronous). Release -> first HS falling edge at 656 ticks + 2 pipeline ticks.
- **Sync periods.** Run 2 frames -> HS period 1600 clocks, low 192. VS low for exactly 2 lines. BLANK_N high for 640 ticks per line on 480 lines. `VGA_SYNC_N` always 0.
- **Top-left pixel.** Write (0,0)=3'b100 -> R=3FF, G=B=0 on `h` 0..3 of `v` 0..3. `h`=4 shows memory-initial black.
- **Bottom-right pixel.** Write (159,119)=3'b111 -> white on `h` 636..639 of `v` 476..479. RGB=0 at `h`=640 (blanking).
- **Out-of-range writes.** Write x=160,y=0 and x=0,y=120 with colour 3'b010 -> no change anywhere; (0,1) and (0,0) remain unchanged.
- **Collision and mid-frame reset.**
  - Write to the address being read that tick -> old colour shown this pass, new colour on the next frame.
  - Reset at `v`=200 -> scan restarts at (0,0) and previously written pixels are still displayed.
